stroke_endpoint_extractor: RTL and testbench

- Inverse of the line renderer: consumes the raster pixel stream with a per-pixel stroke mask from the crayon detector.
- Tracks the leftmost and rightmost stroke pixels over one frame.
- At frame end, emits the stroke as a line segment in the same 84-bit line_coord packing the renderer produces.
- Sits between the mask/threshold stage and the physics/line-drawing stages, with a valid/ready output.

---
 rtl/stroke_endpoint_extractor.sv | 88 ++++++++
 tb/tb_stroke_endpoint_extractor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stroke_endpoint_extractor.sv
// stroke_endpoint_extractor: track leftmost/rightmost stroke pixels per frame and emit them as a line segment
module stroke_endpoint_extractor #(
    parameter int H_ACTIVE   = 1024,
    parameter int V_ACTIVE   = 768,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        is_valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        mask_in,
    input  logic        coord_ready_in,
    output logic [83:0] line_coord,
    output logic        line_valid_out,
    output logic [19:0] pixel_count_out,
    output logic        frame_done_out,
    output logic        overrun_out
);
    typedef enum logic {WAIT_SOF, SCAN} state_t;
    state_t state, state_next;
    logic active, sof, proc, hit, last, eof_q, load;
    logic [10:0] min_x, max_x, min_x_base, max_x_base;
    logic [9:0] min_y, max_y, min_y_base, max_y_base;
    logic [19:0] cnt, cnt_base;

    // pixel qualification, frame-end detection and scan FSM next state
    always_comb begin
        active     = is_valid_in && hcount_in < 11'(H_ACTIVE) && vcount_in < 10'(V_ACTIVE);
        sof        = active && hcount_in == '0 && vcount_in == '0;
        proc       = active && (state == SCAN || sof);
        hit        = proc && mask_in;
        last       = proc && hcount_in == 11'(H_ACTIVE - 1) && vcount_in == 10'(V_ACTIVE - 1);
        state_next = proc ? SCAN : state;
        load       = eof_q && cnt >= 20'(MIN_PIXELS);
    end

    // trackers restart from empty in the cycle their finished frame is reported
    always_comb begin
        cnt_base   = eof_q ? '0 : cnt;
        min_x_base = eof_q ? '0 : min_x;
        min_y_base = eof_q ? '0 : min_y;
        max_x_base = eof_q ? '0 : max_x;
        max_y_base = eof_q ? '0 : max_y;
    end

    // scan FSM state register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= WAIT_SOF;
        else         state <= state_next;
    end

    // strict compares keep the earliest raster pixel on equal x
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            eof_q <= 1'b0;
            cnt   <= '0;
            min_x <= '0;
            min_y <= '0;
            max_x <= '0;
            max_y <= '0;
        end else begin
            eof_q <= last;
            cnt   <= hit && !(&cnt_base) ? cnt_base + 20'd1 : cnt_base;
            {min_x, min_y} <= hit && (cnt_base == '0 || hcount_in < min_x_base) ?
                              {hcount_in, vcount_in} : {min_x_base, min_y_base};
            {max_x, max_y} <= hit && (cnt_base == '0 || hcount_in > max_x_base) ?
                              {hcount_in, vcount_in} : {max_x_base, max_y_base};
        end
    end

    // frame report and single-entry output register with overwrite on overrun
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            line_coord      <= '0;
            line_valid_out  <= 1'b0;
            pixel_count_out <= '0;
            frame_done_out  <= 1'b0;
            overrun_out     <= 1'b0;
        end else begin
            frame_done_out  <= eof_q;
            pixel_count_out <= eof_q ? cnt : pixel_count_out;
            overrun_out     <= load && line_valid_out && !coord_ready_in;
            line_valid_out  <= load || (line_valid_out && !coord_ready_in);
            line_coord      <= load ? {min_x, min_y, max_x, max_y, 42'b0} : line_coord;
        end
    end
endmodule

// File: tb/tb_stroke_endpoint_extractor.sv
// tb_stroke_endpoint_extractor: randomized and directed frames checked against a frame-level reference model
module tb_stroke_endpoint_extractor;
    localparam int H = 32;
    localparam int V = 24;
    localparam int MIN = 16;

    typedef struct packed {logic [10:0] x; logic [9:0] y;} pt_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        is_valid_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        mask_in = 1'b0;
    logic        coord_ready_in = 1'b0;
    logic [83:0] line_coord;
    logic        line_valid_out;
    logic [19:0] pixel_count_out;
    logic        frame_done_out;
    logic        overrun_out;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit rdy = 1'b1;
    bit rnd_rdy = 1'b0;
    bit fmask [V][H];

    logic [83:0] e_coord;
    logic        e_valid, e_fd, e_ov;
    logic [19:0] e_cnt;

    stroke_endpoint_extractor #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MIN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .is_valid_in(is_valid_in), .hcount_in(hcount_in),
        .vcount_in(vcount_in), .mask_in(mask_in), .coord_ready_in(coord_ready_in),
        .line_coord(line_coord), .line_valid_out(line_valid_out), .pixel_count_out(pixel_count_out),
        .frame_done_out(frame_done_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [83:0] lc(input int x1, input int y1, input int x2, input int y2);
        return {11'(x1), 10'(y1), 11'(x2), 10'(y2), 42'b0};
    endfunction

    task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: collect stroke pixels of an armed frame, reduce them at the last pixel
    initial begin
        pt_t q[$];
        bit armed, pend, old;
        logic [83:0] pcoord;
        int pcnt;
        pt_t lo, hi;
        armed = 0; pend = 0; pcnt = 0; pcoord = '0;
        e_coord = '0; e_valid = 0; e_fd = 0; e_ov = 0; e_cnt = '0;
        forever begin
            @(posedge clk_in or negedge rst_in);
            if (!rst_in) begin
                armed = 0; pend = 0; q.delete();
                e_coord = '0; e_valid = 0; e_fd = 0; e_ov = 0; e_cnt = '0;
            end else begin
                e_fd = 0;
                e_ov = 0;
                old = e_valid;
                e_valid = old && !coord_ready_in;
                if (pend) begin
                    e_fd = 1;
                    e_cnt = 20'(pcnt);
                    if (pcnt >= MIN) begin
                        e_ov = old && !coord_ready_in;
                        e_valid = 1;
                        e_coord = pcoord;
                    end
                    pend = 0;
                end
                if (is_valid_in && hcount_in < H && vcount_in < V) begin
                    if (hcount_in == 0 && vcount_in == 0) armed = 1;
                    if (armed && mask_in) q.push_back('{hcount_in, vcount_in});
                    if (armed && hcount_in == H - 1 && vcount_in == V - 1) begin
                        pcnt = q.size() > 20'hFFFFF ? 20'hFFFFF : q.size();
                        if (q.size() > 0) begin
                            lo = q[0];
                            hi = q[0];
                            foreach (q[i]) begin
                                if (q[i].x < lo.x || (q[i].x == lo.x && q[i].y < lo.y)) lo = q[i];
                                if (q[i].x > hi.x || (q[i].x == hi.x && q[i].y < hi.y)) hi = q[i];
                            end
                            pcoord = lc(lo.x, lo.y, hi.x, hi.y);
                        end
                        pend = 1;
                        q.delete();
                    end
                end
            end
        end
    end

    // Compare DUT against the model every cycle
    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk("line_valid", 84'(line_valid_out), 84'(e_valid));
            chk("frame_done", 84'(frame_done_out), 84'(e_fd));
            chk("overrun", 84'(overrun_out), 84'(e_ov));
            chk("pixel_count", 84'(pixel_count_out), 84'(e_cnt));
            if (e_valid) chk("line_coord", line_coord, e_coord);
        end
    end

    task automatic pix(input logic vld, input int h, input int v, input logic m);
        is_valid_in = vld;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        mask_in = m;
        coord_ready_in = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, $urandom_range(0, 2047), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
    endtask

    task automatic clr();
        foreach (fmask[y, x]) fmask[y][x] = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit blank, input int rel_row);
        for (int v = 0; v < V; v++) begin
            if (v == rel_row) rst_in = 1'b1;
            for (int h = 0; h < H; h++) begin
                if (gaps && $urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
                pix(1'b1, h, v, fmask[v][h]);
            end
            if (blank && v < V - 1) begin
                pix(1'b1, 1100, v, 1'b1);
                pix(1'b1, H + $urandom_range(0, 50), v, 1'b1);
                pix(1'b1, 5, 800, 1'b1);
            end
        end
    endtask

    task automatic frame_a();
        clr();
        fmask[5][3] = 1;
        fmask[9][20] = 1;
        for (int x = 5; x <= 18; x++) fmask[7][x] = 1;
    endtask

    task automatic frame_tie();
        clr();
        fmask[2][5] = 1;
        fmask[8][5] = 1;
        fmask[1][28] = 1;
        fmask[12][28] = 1;
        for (int y = 3; y <= 14; y++) fmask[y][15] = 1;
    endtask

    initial begin
        idle(3);
        cmp_en = 1'b1;
        @(negedge clk_in);
        chk("rst_valid", 84'(line_valid_out), 84'd0);
        chk("rst_coord", line_coord, 84'd0);
        chk("rst_count", 84'(pixel_count_out), 84'd0);
        rst_in = 1'b1;
        idle(2);

        // 1: basic segment, 16 pixels
        frame_a();
        send_frame(0, 0, -1);
        idle(1);
        @(negedge clk_in);
        chk("t1_coord", line_coord, lc(3, 5, 20, 9));
        chk("t1_valid", 84'(line_valid_out), 84'd1);
        chk("t1_count", 84'(pixel_count_out), 84'd16);
        chk("t1_done", 84'(frame_done_out), 84'd1);
        idle(3);

        // 2: 15 pixels, below threshold
        frame_a();
        fmask[7][10] = 0;
        send_frame(0, 0, -1);
        idle(1);
        @(negedge clk_in);
        chk("t2_done", 84'(frame_done_out), 84'd1);
        chk("t2_count", 84'(pixel_count_out), 84'd15);
        chk("t2_valid", 84'(line_valid_out), 84'd0);
        idle(3);

        // 3: ties on equal x keep the earliest raster pixel
        frame_tie();
        send_frame(0, 0, -1);
        idle(1);
        @(negedge clk_in);
        chk("t3_coord", line_coord, lc(5, 2, 28, 1));
        idle(3);

        // 4a: overrun when not ready
        rdy = 1'b0;
        frame_tie();
        send_frame(0, 0, -1);
        idle(1);
        frame_a();
        send_frame(0, 0, -1);
        idle(1);
        @(negedge clk_in);
        chk("t4_overrun", 84'(overrun_out), 84'd1);
        chk("t4_coord", line_coord, lc(3, 5, 20, 9));
        rdy = 1'b1;
        idle(1);
        rdy = 1'b0;
        @(negedge clk_in);
        chk("t4_drained", 84'(line_valid_out), 84'd0);
        // 4b: ready exactly on the load cycle
        frame_tie();
        send_frame(0, 0, -1);
        idle(1);
        frame_a();
        send_frame(0, 0, -1);
        rdy = 1'b1;
        idle(1);
        @(negedge clk_in);
        chk("t4b_overrun", 84'(overrun_out), 84'd0);
        chk("t4b_valid", 84'(line_valid_out), 84'd1);
        chk("t4b_coord", line_coord, lc(3, 5, 20, 9));
        idle(3);

        // 5: reset released mid-frame, then a normal 20-pixel frame
        rst_in = 1'b0;
        frame_tie();
        for (int x = 0; x < 20; x++) fmask[16][x] = 1;
        send_frame(0, 0, 10);
        idle(1);
        @(negedge clk_in);
        chk("t5_nodone", 84'(frame_done_out), 84'd0);
        chk("t5_novalid", 84'(line_valid_out), 84'd0);
        clr();
        for (int x = 2; x < 22; x++) fmask[11][x] = 1;
        fmask[11][2] = 0;
        fmask[4][2] = 1;
        send_frame(0, 0, -1);
        idle(1);
        @(negedge clk_in);
        chk("t5_count", 84'(pixel_count_out), 84'd20);
        chk("t5_coord", line_coord, lc(2, 4, 21, 11));
        idle(3);

        // 6: blanking and invalid gaps must not change the result
        frame_a();
        send_frame(1, 1, -1);
        idle(1);
        @(negedge clk_in);
        chk("t6_coord", line_coord, lc(3, 5, 20, 9));
        chk("t6_count", 84'(pixel_count_out), 84'd16);
        idle(3);

        // randomized frames with random downstream readiness
        rnd_rdy = 1'b1;
        for (int f = 0; f < 5; f++) begin
            clr();
            for (int n = $urandom_range(0, 40); n > 0; n--) fmask[$urandom_range(0, V - 1)][$urandom_range(0, H - 1)] = 1;
            send_frame(1, f[0], -1);
            idle($urandom_range(1, 4));
        end
        rnd_rdy = 1'b0;
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
